cdb_broadcast_arbiter: RTL

Shares the single common-data-bus (CDB) broadcast slot among NUM_REQ functional-unit result producers using round-robin arbitration. Sits between the execution units and the ROB/reservation-station wakeup logic. Holds one registered broadcast entry that the arbitration unit releases via allowBroadcast. Reports bus status (ongoingBroadcast, broadcastDataAvailable) back to the arbitration unit.

---
 rtl/cdb_broadcast_arbiter_if.sv | 34 +++
 rtl/cdb_broadcast_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/cdb_broadcast_arbiter_if.sv
// Handshake and broadcast bundle between the functional units, the CDB arbiter
// and the arbitration/wakeup side. The arbiter takes the slave view.
interface cdb_broadcast_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int TAG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                            flush;
    logic                            allowBroadcast;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            bcast_valid;
    logic [TAG_WIDTH-1:0]            bcast_tag;
    logic [DATA_WIDTH-1:0]           bcast_data;
    logic [SRC_W-1:0]                bcast_src;
    logic                            ongoingBroadcast;
    logic                            broadcastDataAvailable;

    modport master (
        output flush, allowBroadcast, req_valid, req_tag, req_data,
        input  req_ready, bcast_valid, bcast_tag, bcast_data, bcast_src,
               ongoingBroadcast, broadcastDataAvailable
    );

    modport slave (
        input  flush, allowBroadcast, req_valid, req_tag, req_data,
        output req_ready, bcast_valid, bcast_tag, bcast_data, bcast_src,
               ongoingBroadcast, broadcastDataAvailable
    );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// Round-robin arbiter for the single CDB broadcast slot: grants one functional
// unit per cycle into a registered entry released by allowBroadcast.
module cdb_broadcast_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TAG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    cdb_broadcast_arbiter_if.slave  bus
);
    localparam int                 SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                 IDX_W = SRC_W + 1;
    localparam logic [IDX_W-1:0]   NUM_W = IDX_W'(NUM_REQ);
    localparam logic [SRC_W-1:0]   LAST_W = SRC_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic                  bcast_valid_q, bcast_valid_d;
    logic [TAG_WIDTH-1:0]  bcast_tag_q,   bcast_tag_d;
    logic [DATA_WIDTH-1:0] bcast_data_q,  bcast_data_d;
    logic [SRC_W-1:0]      bcast_src_q,   bcast_src_d;
    logic [SRC_W-1:0]      ptr_q,         ptr_d;

    logic                  consume_s;
    logic                  load_en_s;
    logic                  grant_s;
    logic                  found_s;
    logic [IDX_W-1:0]      idx_s;
    logic [SRC_W-1:0]      winner_s;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic [TAG_WIDTH-1:0]  tag_arr_s  [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign tag_arr_s[g]  = bus.req_tag[g*TAG_WIDTH +: TAG_WIDTH];
        assign data_arr_s[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Grants are held off during reset so req_ready stays low until release.
    assign consume_s = bcast_valid_q & bus.allowBroadcast;
    assign load_en_s = rst & ~bus.flush & (~bcast_valid_q | bus.allowBroadcast);
    assign grant_s   = load_en_s & (|bus.req_valid);

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, ptr_q} + IDX_W'(k);
            idx_s = (idx_s >= NUM_W) ? (idx_s - NUM_W) : idx_s;
            if (!found_s && bus.req_valid[idx_s[SRC_W-1:0]]) begin
                found_s  = 1'b1;
                winner_s = idx_s[SRC_W-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // One-hot grant vector toward the requesters.
    always_comb begin
        req_ready_s = '0;
        if (grant_s) begin
            req_ready_s = ONE_HOT0 << winner_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next state of the broadcast slot and the round-robin pointer.
    always_comb begin
        bcast_valid_d = bcast_valid_q;
        bcast_tag_d   = bcast_tag_q;
        bcast_data_d  = bcast_data_q;
        bcast_src_d   = bcast_src_q;
        ptr_d         = ptr_q;
        if (grant_s) begin
            bcast_valid_d = 1'b1;
            bcast_tag_d   = tag_arr_s[winner_s];
            bcast_data_d  = data_arr_s[winner_s];
            bcast_src_d   = winner_s;
            ptr_d         = (winner_s == LAST_W) ? '0 : (winner_s + SRC_W'(1));
        end else if (consume_s || bus.flush) begin
            bcast_valid_d = 1'b0;
        end else begin
            bcast_valid_d = bcast_valid_q;
        end
    end

    // Slot and pointer registers; reset drops any held entry immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcast_valid_q <= 1'b0;
            bcast_tag_q   <= '0;
            bcast_data_q  <= '0;
            bcast_src_q   <= '0;
            ptr_q         <= '0;
        end else begin
            bcast_valid_q <= bcast_valid_d;
            bcast_tag_q   <= bcast_tag_d;
            bcast_data_q  <= bcast_data_d;
            bcast_src_q   <= bcast_src_d;
            ptr_q         <= ptr_d;
        end
    end

    assign bus.req_ready              = req_ready_s;
    assign bus.bcast_valid            = bcast_valid_q;
    assign bus.bcast_tag              = bcast_tag_q;
    assign bus.bcast_data             = bcast_data_q;
    assign bus.bcast_src              = bcast_src_q;
    assign bus.ongoingBroadcast       = bcast_valid_q;
    assign bus.broadcastDataAvailable = |bus.req_valid;

endmodule
